// File: rtl/div_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : div_arbiter_if
// Purpose  : Requester, response and divider-side signals of div_arbiter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface div_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   Req;
    logic [8*NREQ-1:0] XReq;
    logic [8*NREQ-1:0] YReq;
    logic [NREQ-1:0]   Gnt;
    logic [NREQ-1:0]   RspValid;
    logic [NREQ-1:0]   RspAck;
    logic [7:0]        Quot;
    logic [7:0]        Rem;
    logic              DivErr;
    logic              Busy;
    logic [7:0]        DivXin;
    logic [7:0]        DivYin;
    logic              DivStart;
    logic              DivAck;
    logic              DivDone;
    logic [7:0]        DivQuotient;
    logic [7:0]        DivRemainder;

    // Arbiter side
    modport slave (
        input  Req, XReq, YReq, RspAck, DivDone, DivQuotient, DivRemainder,
        output Gnt, RspValid, Quot, Rem, DivErr, Busy,
               DivXin, DivYin, DivStart, DivAck
    );

    // Requesters plus divider side
    modport master (
        output Req, XReq, YReq, RspAck, DivDone, DivQuotient, DivRemainder,
        input  Gnt, RspValid, Quot, Rem, DivErr, Busy,
               DivXin, DivYin, DivStart, DivAck
    );
endinterface
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : div_arbiter
// Purpose  : Shares one 8-bit iterative divider among NREQ requesters.
//            DIVARB_RR_EN defined selects round-robin, else fixed priority.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module div_arbiter #(
    parameter int NREQ = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    div_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] c_LAST = PW'(NREQ - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_LAUNCH = 4'b0010,
        S_WAIT   = 4'b0100,
        S_RESP   = 4'b1000
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_xr;
    logic [7:0]      r_yr;
    logic [7:0]      r_quot;
    logic [7:0]      r_rem;
    logic            r_err;
    logic [PW-1:0]   r_owner;
    logic            w_any;
    logic [PW-1:0]   w_win;
    logic [7:0]      w_xsel;
    logic [7:0]      w_ysel;

`ifdef DIVARB_RR_EN
    localparam logic [PW:0] c_NREQ = (PW+1)'(NREQ);
    logic [PW-1:0]   r_ptr;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0] w_rot;
    logic [PW:0]     w_sum;

    assign w_dbl = {bus.Req, bus.Req};
    assign w_rot = w_dbl[r_ptr +: NREQ];

    // Search from the pointer upward; descending loop lets the nearest win.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_ptr} + (PW+1)'(k);
                if (w_sum >= c_NREQ) begin
                    w_sum = w_sum - c_NREQ;
                end
                w_win = w_sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= (w_win == c_LAST) ? '0 : w_win + PW'(1);
        end
    end
`else
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.Req[k]) begin
                w_any = 1'b1;
                w_win = PW'(k);
            end
        end
    end
`endif

    assign w_xsel = bus.XReq[{w_win, 3'b000} +: 8];
    assign w_ysel = bus.YReq[{w_win, 3'b000} +: 8];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Gnt is masked during reset so every output reads zero while it is held.
    always_comb begin
        w_next       = r_state;
        bus.Gnt      = '0;
        bus.RspValid = '0;
        bus.DivStart = 1'b0;
        bus.DivAck   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any && !Reset) begin
                    bus.Gnt[w_win] = 1'b1;
                    w_next = (w_ysel == 8'd0) ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                bus.DivStart = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                bus.DivAck = bus.DivDone;
                if (bus.DivDone) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.RspValid[r_owner] = 1'b1;
                if (bus.RspAck[r_owner]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A zero divisor is answered directly; the divider would never finish.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_xr    <= '0;
            r_yr    <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_err   <= 1'b0;
            r_owner <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_xr    <= w_xsel;
            r_yr    <= w_ysel;
            r_owner <= w_win;
            if (w_ysel == 8'd0) begin
                r_quot <= 8'hFF;
                r_rem  <= w_xsel;
                r_err  <= 1'b1;
            end else begin
                r_err  <= 1'b0;
            end
        end else if (r_state == S_WAIT && bus.DivDone) begin
            r_quot <= bus.DivQuotient;
            r_rem  <= bus.DivRemainder;
        end
    end

    assign bus.Busy   = (r_state != S_IDLE);
    assign bus.Quot   = r_quot;
    assign bus.Rem    = r_rem;
    assign bus.DivErr = r_err;
    assign bus.DivXin = r_xr;
    assign bus.DivYin = r_yr;
endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_div_arbiter
// Purpose  : Directed scoreboard bench for div_arbiter with a divider model.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_div_arbiter;
    logic Clk = 1'b0;
    logic Reset;

    div_arbiter_if #(.NREQ(4)) bus ();
    div_arbiter #(.NREQ(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    typedef struct {
        int owner;
        int q;
        int r;
        int err;
        int lat;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   gnt_cyc, st_cnt, ack_cnt, st_cyc, ack_cyc;
    bit   in_rsp = 1'b0;
    bit   mon_en = 1'b1;
    bit   ack_auto = 1'b1;
    logic [3:0] ack_manual = 4'b0;

    // Repeated-subtraction divider: q+1 compute cycles, Done held until Ack.
    logic [1:0] dv_st;
    logic [7:0] dv_x, dv_y, dv_q;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dv_st <= 2'd0; dv_x <= 8'd0; dv_y <= 8'd0; dv_q <= 8'd0;
        end else begin
            case (dv_st)
                2'd0: begin
                    dv_x <= bus.DivXin; dv_y <= bus.DivYin; dv_q <= 8'd0;
                    if (bus.DivStart) dv_st <= 2'd1;
                end
                2'd1: begin
                    if (dv_x >= dv_y) begin
                        dv_x <= dv_x - dv_y; dv_q <= dv_q + 8'd1;
                    end else begin
                        dv_st <= 2'd2;
                    end
                end
                default: if (bus.DivAck) dv_st <= 2'd0;
            endcase
        end
    end
    assign bus.DivDone      = (dv_st == 2'd2);
    assign bus.DivQuotient  = dv_q;
    assign bus.DivRemainder = dv_x;
    assign bus.RspAck       = ack_auto ? bus.RspValid : ack_manual;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: grant and response checks against the scoreboard head.
    always @(negedge Clk) begin
        if (!Reset && mon_en) begin
            if (|bus.Gnt) begin
                if (sbq.size() == 0) chk("unexpected_gnt", int'(bus.Gnt), 0);
                else chk("gnt_onehot", int'(bus.Gnt), 1 << sbq[0].owner);
                gnt_cyc = cyc; st_cnt = 0; ack_cnt = 0; st_cyc = -1; ack_cyc = -1;
            end
            if (bus.DivStart) begin st_cnt++; st_cyc = cyc; end
            if (bus.DivAck) begin ack_cnt++; ack_cyc = cyc; end
            if ((|bus.RspValid) && !in_rsp) begin
                in_rsp = 1'b1;
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", int'(bus.RspValid), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_owner", int'(bus.RspValid), 1 << e.owner);
                    chk("quot", int'(bus.Quot), e.q);
                    chk("rem", int'(bus.Rem), e.r);
                    chk("diverr", int'(bus.DivErr), e.err);
                    chk("rsp_latency", cyc - gnt_cyc, e.lat);
                    chk("start_count", st_cnt, (e.err != 0) ? 0 : 1);
                    if (e.err == 0) begin
                        chk("start_cycle", st_cyc - gnt_cyc, 1);
                        chk("ack_count", ack_cnt, 1);
                        chk("ack_cycle", ack_cyc - gnt_cyc, e.lat - 1);
                    end
                end
            end
            if (!(|bus.RspValid)) in_rsp = 1'b0;
        end
    end

    task automatic issue(input int i, input int x, input int y);
        int k;
        @(posedge Clk); #1;
        bus.Req[i] = 1'b1;
        bus.XReq[8*i +: 8] = 8'(x);
        bus.YReq[8*i +: 8] = 8'(y);
        for (k = 0; k < 100; k++) begin
            #1;
            if (bus.Gnt[i]) break;
            @(posedge Clk); #1;
        end
        if (k == 100) chk("gnt_timeout", 0, 1);
        @(posedge Clk); #1;
        bus.Req[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            if (!bus.Busy) break;
            @(posedge Clk); #1;
        end
        if (k == 300) chk("idle_timeout", 0, 1);
    endtask

    task automatic run_op(input int i, input int x, input int y,
                          input int q, input int r, input int err, input int lat);
        sbq.push_back('{i, q, r, err, lat});
        issue(i, x, y);
        wait_idle();
    endtask

    initial begin
        int rc;
        int k;
        Reset = 1'b1;
        bus.Req = '0; bus.XReq = '0; bus.YReq = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_busy", int'(bus.Busy), 0);
        chk("reset_quot_rem_err", int'({bus.Quot, bus.Rem, bus.DivErr}), 0);
        chk("reset_divxy", int'({bus.DivXin, bus.DivYin}), 0);
        Reset = 1'b0;

        run_op(0, 100, 7, 14, 2, 0, 18);
        run_op(2, 3, 9, 0, 3, 0, 4);
        run_op(1, 55, 0, 255, 55, 1, 1);

        // Foreign acknowledge must not end owner 0's response.
        ack_auto = 1'b0;
        sbq.push_back('{0, 3, 0, 0, 7});
        issue(0, 9, 3);
        for (k = 0; k < 100; k++) begin
            if (|bus.RspValid) break;
            @(posedge Clk); #1;
        end
        if (k == 100) chk("rsp_timeout", 0, 1);
        ack_manual = 4'b1000;
        repeat (2) begin @(posedge Clk); #1; end
        chk("ignored_ack_valid", int'(bus.RspValid), 1);
        chk("ignored_ack_quot", int'(bus.Quot), 3);
        chk("ignored_ack_busy", int'(bus.Busy), 1);
        ack_manual = 4'b0001;
        @(posedge Clk); #1;
        chk("owner_ack_idle", int'(bus.Busy), 0);
        chk("owner_ack_valid", int'(bus.RspValid), 0);
        ack_manual = 4'b0000;
        ack_auto = 1'b1;

        // Reset in the middle of WAIT.
        mon_en = 1'b0;
        issue(1, 100, 7);
        repeat (5) begin @(posedge Clk); #1; end
        chk("pre_reset_busy", int'(bus.Busy), 1);
        Reset = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.Busy), 0);
        chk("midrst_divxy", int'({bus.DivXin, bus.DivYin}), 0);
        chk("midrst_ctl", int'({bus.Gnt, bus.RspValid, bus.DivStart, bus.DivAck}), 0);
        chk("midrst_quot_rem_err", int'({bus.Quot, bus.Rem, bus.DivErr}), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        mon_en = 1'b1;
        run_op(3, 200, 10, 20, 0, 0, 24);

        // All four requesting, immediate acknowledge.
`ifdef DIVARB_RR_EN
        for (int i = 0; i < 4; i++) sbq.push_back('{i, 2*(i+1), i, 0, 2*(i+1)+4});
        sbq.push_back('{0, 2, 0, 0, 6});
`else
        for (int i = 0; i < 5; i++) sbq.push_back('{0, 2, 0, 0, 6});
`endif
        @(posedge Clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus.XReq[8*i +: 8] = 8'(10*(i+1) + i);
            bus.YReq[8*i +: 8] = 8'd5;
        end
        bus.Req = 4'hF;
        rc = 0;
        for (k = 0; k < 400; k++) begin
            @(posedge Clk); #1;
            if (|bus.RspValid) rc++;
            if (rc == 5) break;
        end
        bus.Req = '0;
        if (k == 400) chk("order_timeout", rc, 5);
        @(posedge Clk); #1;
        wait_idle();
        repeat (2) @(posedge Clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
